arb_mux: RTL and testbench

- Parametrised N-channel, valid/ready successor to the 2:1 combinational operand mux.
- Selects one of NUM_CH requesting sources by fixed priority, round-robin, or an external select, and registers the winner into a one-entry output stage.
- Used where several CPU sources share one sink, e.g. IF/MEM requests onto a single memory port, or multiple writeback sources onto the register-file write port.
- Full throughput: one transfer per cycle with 1-cycle latency.

---
 rtl/cpu_pkg.sv | 18 +
 rtl/rr_arbiter.sv | 65 ++++++
 rtl/arb_mux.sv | 88 ++++++++
 tb/tb_arb_mux.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU interconnect blocks: arbitration mode
// encodings and the helper that sizes channel-index fields.
package cpu_pkg;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;
    localparam int ARB_SEL   = 2;

    // Width needed to index n channels, never less than one bit so that a
    // two-channel (or degenerate) configuration still has a usable field.
    function automatic int clog2_min1(input int n);
        if (n <= 2) begin
            return 1;
        end
        return $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational arbiter: picks at most one requester by fixed priority,
// round-robin from a supplied pointer, or an external select, and reports
// the winner both one-hot and as an index.
module rr_arbiter
    import cpu_pkg::*;
#(
    parameter int NUM_CH = 2,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    input  logic [1:0]        mode,
    input  logic [SEL_W-1:0]  sel,
    output logic [NUM_CH-1:0] grant,
    output logic [SEL_W-1:0]  grant_idx
);

    // Grant selection; the first match in search order wins and later
    // candidates are masked by the found flag, keeping the grant one-hot.
    always_comb begin
        logic found;
        int   cand;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = 0;
        case (int'(mode))
            ARB_FIXED: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (!found && req[i]) begin
                        found     = 1'b1;
                        grant[i]  = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            ARB_RR: begin
                for (int j = 0; j < NUM_CH; j++) begin
                    cand = int'(ptr) + j;
                    if (cand >= NUM_CH) begin
                        cand = cand - NUM_CH;
                    end
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (!found && cand == i && req[i]) begin
                            found     = 1'b1;
                            grant[i]  = 1'b1;
                            grant_idx = SEL_W'(i);
                        end
                    end
                end
            end
            ARB_SEL: begin
                for (int i = 0; i < NUM_CH; i++) begin
                    if (sel == SEL_W'(i) && req[i]) begin
                        grant[i]  = 1'b1;
                        grant_idx = SEL_W'(i);
                    end
                end
            end
            default: begin
            end
        endcase
    end

endmodule

// File: rtl/arb_mux.sv
// N-channel valid/ready arbitrating mux with a one-entry registered output
// stage. One transfer per cycle, one cycle of latency. in_ready depends
// combinationally on out_ready; out_data does not.
module arb_mux
    import cpu_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int NUM_CH = 2,
    parameter int MODE   = ARB_RR,
    parameter int SEL_W  = clog2_min1(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_CH-1:0]       in_valid,
    input  logic [NUM_CH*WIDTH-1:0] in_data,
    output logic [NUM_CH-1:0]       in_ready,
    output logic                    out_valid,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_ch,
    input  logic                    out_ready
);

    logic [NUM_CH-1:0] grant;
    logic [SEL_W-1:0]  grant_idx;
    logic [SEL_W-1:0]  rr_ptr;
    logic [WIDTH-1:0]  grant_data;
    logic              load;
    logic              any_grant;

    rr_arbiter #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_arb (
        .req       (in_valid),
        .ptr       (rr_ptr),
        .mode      (2'(MODE)),
        .sel       (sel),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    assign load      = ~out_valid | out_ready;
    assign any_grant = |grant;
    assign in_ready  = (rstn && load) ? grant : '0;

    // AND-OR mux of the granted channel's data, driven by the one-hot grant.
    always_comb begin
        grant_data = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (grant[i]) begin
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Output stage: capture the winner when empty or draining, otherwise hold.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_ch    <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= grant_data;
                out_ch    <= grant_idx;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Round-robin pointer moves past the winner only on a completed input
    // handshake; the wrap is an explicit compare for non-power-of-two counts.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rr_ptr <= '0;
        end else if (load && any_grant) begin
            if (grant_idx == SEL_W'(NUM_CH - 1)) begin
                rr_ptr <= '0;
            end else begin
                rr_ptr <= grant_idx + SEL_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_arb_mux.sv
// Self-checking bench for arb_mux: five configurations run side by side on
// shared clock and reset, each compared every cycle against a behavioural
// model of the arbitration and output-register rules.
module tb_arb_mux;
    import cpu_pkg::*;

    localparam int NI = 5;

    // Instance configurations: channel count and arbitration mode.
    function automatic int nch(input int k);
        case (k)
            0: return 4;
            1: return 3;
            2: return 5;
            3: return 3;
            default: return 4;
        endcase
    endfunction

    function automatic int mode_of(input int k);
        case (k)
            0: return ARB_FIXED;
            1: return ARB_RR;
            2: return ARB_RR;
            3: return ARB_SEL;
            default: return ARB_RR;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rstn;
    logic [7:0]  vld   [NI];
    logic [31:0] dat   [NI][8];
    logic [7:0]  sel_a [NI];
    logic        ordy  [NI];
    logic [7:0]  rdy_a [NI];
    logic        ov_a  [NI];
    logic [31:0] od_a  [NI];
    logic [7:0]  oc_a  [NI];

    logic        m_valid [NI];
    logic [31:0] m_data  [NI];
    int          m_ch    [NI];
    int          m_ptr   [NI];
    logic [7:0]  m_acc   [NI];

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    generate
        for (genvar k = 0; k < NI; k++) begin : g_dut
            localparam int N  = nch(k);
            localparam int SW = clog2_min1(N);
            logic [N*32-1:0] pd;
            logic [N-1:0]    rdy;
            logic [SW-1:0]   oc;
            logic            ov;
            logic [31:0]     od;
            for (genvar i = 0; i < N; i++) begin : g_pack
                assign pd[i*32 +: 32] = dat[k][i];
            end
            arb_mux #(
                .WIDTH  (32),
                .NUM_CH (N),
                .MODE   (mode_of(k))
            ) u_dut (
                .clk       (clk),
                .rstn      (rstn),
                .sel       (sel_a[k][SW-1:0]),
                .in_valid  (vld[k][N-1:0]),
                .in_data   (pd),
                .in_ready  (rdy),
                .out_valid (ov),
                .out_data  (od),
                .out_ch    (oc),
                .out_ready (ordy[k])
            );
            assign rdy_a[k] = 8'(rdy);
            assign ov_a[k]  = ov;
            assign od_a[k]  = od;
            assign oc_a[k]  = 8'(oc);
        end
    endgenerate

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < NI; k++) begin
            m_valid[k] = 1'b0;
            m_data[k]  = '0;
            m_ch[k]    = 0;
            m_ptr[k]   = 0;
            m_acc[k]   = '0;
        end
    endtask

    // Winning channel by the arbitration rules, or -1 when nothing is granted.
    function automatic int expGrant(input int k);
        int n;
        int s;
        n = nch(k);
        case (mode_of(k))
            ARB_FIXED: begin
                for (int i = 0; i < n; i++) if (vld[k][i]) return i;
            end
            ARB_RR: begin
                for (int j = 0; j < n; j++) if (vld[k][(m_ptr[k] + j) % n]) return (m_ptr[k] + j) % n;
            end
            default: begin
                s = int'(sel_a[k]) % (1 << clog2_min1(n));
                if (s < n && vld[k][s]) return s;
            end
        endcase
        return -1;
    endfunction

    // One clock cycle with the currently driven inputs: check in_ready before
    // the edge, advance the model, then check the registered outputs.
    task automatic applyStimulus();
        int   g    [NI];
        logic ld   [NI];
        logic [7:0] er;
        #2;
        for (int k = 0; k < NI; k++) begin
            g[k]  = expGrant(k);
            ld[k] = !m_valid[k] || ordy[k];
            er    = (rstn && ld[k] && g[k] >= 0) ? 8'(1 << g[k]) : 8'h00;
            m_acc[k] = er;
            checkOutput($sformatf("d%0d.in_ready", k), 32'(rdy_a[k]), 32'(er));
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < NI; k++) begin
            if (ld[k]) begin
                if (g[k] >= 0) begin
                    m_valid[k] = 1'b1;
                    m_data[k]  = dat[k][g[k]];
                    m_ch[k]    = g[k];
                    m_ptr[k]   = (g[k] + 1) % nch(k);
                end else begin
                    m_valid[k] = 1'b0;
                end
            end
            checkOutput($sformatf("d%0d.out_valid", k), 32'(ov_a[k]), 32'(m_valid[k]));
            checkOutput($sformatf("d%0d.out_ch", k), 32'(oc_a[k]), 32'(m_ch[k]));
            checkOutput($sformatf("d%0d.out_data", k), od_a[k], m_data[k]);
        end
    endtask

    task automatic checkResetState();
        for (int k = 0; k < NI; k++) begin
            checkOutput($sformatf("d%0d.rst_out_valid", k), 32'(ov_a[k]), 32'd0);
            checkOutput($sformatf("d%0d.rst_out_data", k), od_a[k], 32'd0);
            checkOutput($sformatf("d%0d.rst_out_ch", k), 32'(oc_a[k]), 32'd0);
            checkOutput($sformatf("d%0d.rst_in_ready", k), 32'(rdy_a[k]), 32'd0);
        end
    endtask

    task automatic driveAll(input logic [7:0] v, input logic r, input logic [7:0] s);
        for (int k = 0; k < NI; k++) begin
            vld[k]   = v;
            ordy[k]  = r;
            sel_a[k] = s;
        end
    endtask

    task automatic defaultData();
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 8; i++) dat[k][i] = 32'h100 + 32'(i);
        end
    endtask

    task automatic randomCycle();
        int n;
        for (int k = 0; k < NI; k++) begin
            n = nch(k);
            for (int i = 0; i < n; i++) begin
                if (!(vld[k][i] && !m_acc[k][i])) begin
                    vld[k][i] = ($urandom_range(0, 2) != 0);
                    dat[k][i] = $urandom;
                end
            end
            ordy[k]  = ($urandom_range(0, 3) != 0);
            sel_a[k] = 8'($urandom_range(0, (1 << clog2_min1(n)) - 1));
        end
        applyStimulus();
    endtask

    initial begin
        rstn = 1'b0;
        defaultData();
        driveAll(8'hFF, 1'b1, 8'd0);
        modelReset();
        #3;
        checkResetState();
        @(negedge clk);
        rstn = 1'b1;

        $display("[TB] round-robin fairness");
        repeat (6) applyStimulus();

        $display("[TB] fixed priority");
        driveAll(8'b1010, 1'b1, 8'd2);
        repeat (3) applyStimulus();
        driveAll(8'b1000, 1'b1, 8'd2);
        repeat (2) applyStimulus();

        $display("[TB] back-pressure");
        driveAll(8'hFF, 1'b1, 8'd1);
        applyStimulus();
        driveAll(8'hFF, 1'b0, 8'd1);
        repeat (3) applyStimulus();
        driveAll(8'hFF, 1'b1, 8'd1);
        repeat (2) applyStimulus();

        $display("[TB] external select");
        for (int k = 0; k < NI; k++) dat[k][2] = 32'hCAFE;
        driveAll(8'hFF, 1'b1, 8'd2);
        repeat (2) applyStimulus();
        driveAll(8'hFF, 1'b1, 8'd3);
        repeat (3) applyStimulus();
        defaultData();

        $display("[TB] non-power-of-two wrap");
        driveAll(8'b10001, 1'b1, 8'd0);
        repeat (6) applyStimulus();

        $display("[TB] reset during stall");
        for (int k = 0; k < NI; k++) dat[k][0] = 32'hDEAD_BEEF;
        driveAll(8'b0001, 1'b1, 8'd0);
        applyStimulus();
        driveAll(8'b0000, 1'b0, 8'd0);
        applyStimulus();
        driveAll(8'hFF, 1'b0, 8'd0);
        #2;
        rstn = 1'b0;
        #1;
        modelReset();
        checkResetState();
        #1;
        rstn = 1'b1;
        defaultData();
        driveAll(8'hFF, 1'b1, 8'd0);
        repeat (4) applyStimulus();

        $display("[TB] randomized traffic");
        driveAll(8'h00, 1'b1, 8'd0);
        repeat (400) randomCycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
